// File: rtl/traffic_light_fsm.sv
// Tick-timed traffic light controller: main/side street lamps with sensor-extended greens.
// Optional pedestrian WALK phase is built only when the TLC_WALK_EN macro is defined.
module traffic_light_fsm #(
  parameter int T_BASE = 6,
  parameter int T_EXT  = 3,
  parameter int T_YEL  = 2
) (
  input  logic       clk,
  input  logic       Reset_n,
  input  logic       Tick,
  input  logic       Sensor_Sync,
  input  logic       WR_Sync,
  input  logic       Prog_Sync,
  output logic [2:0] Main_Lights,
  output logic [2:0] Side_Lights,
  output logic       Walk_Lamp,
  output logic       Walk_Pending
);

  typedef enum logic [2:0] {
    S_MG   = 3'd0,
    S_MGX  = 3'd1,
    S_MY   = 3'd2,
    S_WALK = 3'd3,
    S_SG   = 3'd4,
    S_SGX  = 3'd5,
    S_SY   = 3'd6
  } state_t;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  // Counter reload is (duration-1); durations of 0 behave as 1, oversize values saturate at 15.
  function automatic logic [3:0] f_load(input int v);
    if (v < 1)       return 4'd0;
    else if (v > 15) return 4'd14;
    else             return 4'(v - 1);
  endfunction

  localparam logic [3:0] L_BASE = f_load(T_BASE);
  localparam logic [3:0] L_EXT  = f_load(T_EXT);
  localparam logic [3:0] L_YEL  = f_load(T_YEL);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;
  logic       w_expire;
  logic       w_load;
  logic       w_pend_next;
  logic [2:0] w_main;
  logic [2:0] w_side;
  logic       w_walk;
  logic       w_unused;

  assign w_unused = WR_Sync;

  // State register, dwell counter and registered outputs.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= S_MG;
      r_cnt        <= L_BASE;
      Main_Lights  <= LAMP_G;
      Side_Lights  <= LAMP_R;
      Walk_Lamp    <= 1'b0;
      Walk_Pending <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      r_state      <= w_next;
      r_cnt        <= w_cnt_next;
      Main_Lights  <= w_main;
      Side_Lights  <= w_side;
      Walk_Lamp    <= w_walk;
      Walk_Pending <= w_pend_next;
    end
  end

  // Next-state, counter and walk-request logic.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch can be inferred.
    w_next      = r_state;
    w_cnt_next  = r_cnt;
    w_pend_next = 1'b0;
    w_expire    = Tick && (r_cnt == 4'd0);

    if (Prog_Sync) begin
      w_next = S_MG;
    end else begin
      case (r_state)
        S_MG:  if (w_expire) w_next = Sensor_Sync ? S_MGX : S_MY;
        S_MGX: if (w_expire) w_next = S_MY;
`ifdef TLC_WALK_EN
        S_MY:   if (w_expire) w_next = Walk_Pending ? S_WALK : S_SG;
        S_WALK: if (w_expire) w_next = S_SG;
`else
        S_MY:   if (w_expire) w_next = S_SG;
`endif
        S_SG:  if (w_expire) w_next = Sensor_Sync ? S_SGX : S_SY;
        S_SGX: if (w_expire) w_next = S_SY;
        S_SY:  if (w_expire) w_next = S_MG;
        default: w_next = S_MG;
      endcase
    end

    // No state loops to itself, so a state change always means a fresh dwell.
    w_load = Prog_Sync || (w_next != r_state);
    if (w_load) begin
      case (w_next)
        S_MGX, S_SGX, S_WALK: w_cnt_next = L_EXT;
        S_MY, S_SY:           w_cnt_next = L_YEL;
        default:              w_cnt_next = L_BASE;
      endcase
    end else if (Tick && (r_cnt != 4'd0)) begin
      w_cnt_next = r_cnt - 4'd1;
    end

`ifdef TLC_WALK_EN
    if (Prog_Sync)
      w_pend_next = 1'b0;
    else if ((w_next == S_WALK) && (r_state != S_WALK))
      w_pend_next = 1'b0;
    else if (r_state == S_WALK)
      w_pend_next = Walk_Pending;
    else
      w_pend_next = Walk_Pending | WR_Sync;
`endif
  end

  // Lamp decode of the upcoming state, so lamps switch on the same edge as the state.
  always_comb begin
    w_main = LAMP_R;
    w_side = LAMP_R;
    w_walk = 1'b0;
    case (w_next)
      S_MG, S_MGX: w_main = LAMP_G;
      S_MY:        w_main = LAMP_Y;
      S_SG, S_SGX: w_side = LAMP_G;
      S_SY:        w_side = LAMP_Y;
`ifdef TLC_WALK_EN
      S_WALK:      w_walk = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Self-checking bench for traffic_light_fsm: directed phases plus random traffic against a
// phase/elapsed-tick reference model; honours TLC_WALK_EN the same way as the design.
module tb_traffic_light_fsm;

  localparam int P_MG = 0, P_MGX = 1, P_MY = 2, P_WALK = 3, P_SG = 4, P_SGX = 5, P_SY = 6;
`ifdef TLC_WALK_EN
  localparam bit WALK_EN = 1'b1;
`else
  localparam bit WALK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       Reset_n, Tick, Sensor_Sync, WR_Sync, Prog_Sync;
  logic [2:0] Main_Lights, Side_Lights;
  logic       Walk_Lamp, Walk_Pending;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: current phase, Ticks already spent in it, latched walk request.
  int m_ph;
  int m_done;
  bit m_pend;

  // Observed-duration bookkeeping, in Ticks, taken from the DUT lamps.
  logic [2:0] prev_main, prev_side;
  logic       prev_walk;
  int since_mg, cnt_mg, cnt_sg, cnt_walk;
  int last_period, last_mg, last_sg, last_walk;

  traffic_light_fsm dut (
    .clk         (clk),
    .Reset_n     (Reset_n),
    .Tick        (Tick),
    .Sensor_Sync (Sensor_Sync),
    .WR_Sync     (WR_Sync),
    .Prog_Sync   (Prog_Sync),
    .Main_Lights (Main_Lights),
    .Side_Lights (Side_Lights),
    .Walk_Lamp   (Walk_Lamp),
    .Walk_Pending(Walk_Pending)
  );

  always #5 clk = ~clk;

  function automatic int dur(input int ph);
    case (ph)
      P_MG, P_SG:          return 6;
      P_MGX, P_SGX, P_WALK: return 3;
      default:             return 2;
    endcase
  endfunction

  function automatic logic [2:0] main_exp(input int ph);
    if (ph == P_MG || ph == P_MGX) return 3'b001;
    if (ph == P_MY)                return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [2:0] side_exp(input int ph);
    if (ph == P_SG || ph == P_SGX) return 3'b001;
    if (ph == P_SY)                return 3'b010;
    return 3'b100;
  endfunction

  function automatic int succ(input int ph, input bit s, input bit pend);
    case (ph)
      P_MG:    return s ? P_MGX : P_MY;
      P_MGX:   return P_MY;
      P_MY:    return (WALK_EN && pend) ? P_WALK : P_SG;
      P_WALK:  return P_SG;
      P_SG:    return s ? P_SGX : P_SY;
      P_SGX:   return P_SY;
      default: return P_MG;
    endcase
  endfunction

  task automatic model_reset();
    m_ph = P_MG; m_done = 0; m_pend = 1'b0;
  endtask

  task automatic model_step(input bit t, input bit s, input bit w, input bit p);
    int nxt;
    if (p) begin
      model_reset();
    end else begin
      nxt = m_ph;
      if (t) begin
        m_done++;
        if (m_done >= dur(m_ph)) begin
          nxt    = succ(m_ph, s, m_pend);
          m_done = 0;
        end
      end
      if (WALK_EN) begin
        if (nxt == P_WALK && m_ph != P_WALK) m_pend = 1'b0;
        else if (m_ph != P_WALK)             m_pend = m_pend | w;
      end
      m_ph = nxt;
    end
  endtask

  task automatic meas_reset();
    prev_main = Main_Lights; prev_side = Side_Lights; prev_walk = Walk_Lamp;
    since_mg = 0; cnt_mg = 0; cnt_sg = 0; cnt_walk = 0;
  endtask

  task automatic measure(input bit t);
    if (t) begin
      since_mg++;
      if (prev_main == 3'b001) cnt_mg++;
      if (prev_side == 3'b001) cnt_sg++;
      if (prev_walk)           cnt_walk++;
    end
    if (prev_main != 3'b001 && Main_Lights == 3'b001) begin last_period = since_mg; since_mg = 0; end
    if (prev_main == 3'b001 && Main_Lights != 3'b001) begin last_mg = cnt_mg; cnt_mg = 0; end
    if (prev_side == 3'b001 && Side_Lights != 3'b001) begin last_sg = cnt_sg; cnt_sg = 0; end
    if (prev_walk && !Walk_Lamp) begin last_walk = cnt_walk; cnt_walk = 0; end
    prev_main = Main_Lights; prev_side = Side_Lights; prev_walk = Walk_Lamp;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("main_lights", Main_Lights, main_exp(m_ph));
    check("side_lights", Side_Lights, side_exp(m_ph));
    check("walk_lamp", Walk_Lamp, (m_ph == P_WALK));
    check("walk_pending", Walk_Pending, m_pend);
  endtask

  // One clock: drive inputs, take the edge, step the model, then compare 1 time unit later.
  task automatic cycle(input bit t, input bit s, input bit w, input bit p);
    Tick = t; Sensor_Sync = s; WR_Sync = w; Prog_Sync = p;
    @(posedge clk);
    model_step(t, s, w, p);
    cyc++;
    #1;
    measure(t);
    check_model();
  endtask

  task automatic run(input int n, input bit s, input bit w);
    for (int i = 0; i < n; i++) cycle((cyc % 10) == 9, s, w, 1'b0);
  endtask

  initial begin
    int n;
    last_period = 0; last_mg = 0; last_sg = 0; last_walk = 0;
    Reset_n = 1'b0; Tick = 1'b0; Sensor_Sync = 1'b0; WR_Sync = 1'b0; Prog_Sync = 1'b0;
    model_reset();
    #12;
    check("rst_main", Main_Lights, 3'b001);
    check("rst_side", Side_Lights, 3'b100);
    check("rst_walk", Walk_Lamp, 1'b0);
    check("rst_pend", Walk_Pending, 1'b0);
    @(negedge clk);
    Reset_n = 1'b1;
    meas_reset();

    // Default timing, no requests: 6+2+6+2 Ticks.
    run(400, 1'b0, 1'b0);
    check("dflt_period", last_period, 16);
    check("dflt_main_green", last_mg, 6);
    check("dflt_side_green", last_sg, 6);

    // Sensor held: both greens extended by T_EXT.
    run(500, 1'b1, 1'b0);
    check("sens_period", last_period, 22);
    check("sens_main_green", last_mg, 9);
    check("sens_side_green", last_sg, 9);

`ifdef TLC_WALK_EN
    // One-clock walk request in MG is served after MY.
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("walk_pend_set", Walk_Pending, 1'b1);
    run(300, 1'b0, 1'b0);
    check("walk_ticks", last_walk, 3);
`else
    // Walk requests are ignored when the walk phase is not built.
    run(500, 1'b0, 1'b1);
    check("nowalk_period", last_period, 16);
    check("nowalk_walk_ticks", last_walk, 0);
`endif

    // Reprogram during SG with a walk request pending.
    n = 0;
    while (Side_Lights != 3'b001 && n < 400) begin run(1, 1'b0, 1'b0); n++; end
    check("reach_sg", (n < 400), 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("prog_main", Main_Lights, 3'b001);
    check("prog_side", Side_Lights, 3'b100);
    check("prog_pend", Walk_Pending, 1'b0);
    n = 0;
    while (Main_Lights == 3'b001 && n < 400) begin run(1, 1'b0, 1'b0); n++; end
    check("prog_leave_mg", (n < 400), 1'b1);
    check("prog_mg_ticks", last_mg, 6);

    // Asynchronous reset in the middle of SY, between clock edges.
    n = 0;
    while (Side_Lights != 3'b010 && n < 400) begin run(1, 1'b0, 1'b0); n++; end
    check("reach_sy", (n < 400), 1'b1);
    #2;
    Reset_n = 1'b0;
    #1;
    check("async_rst_main", Main_Lights, 3'b001);
    check("async_rst_side", Side_Lights, 3'b100);
    check("async_rst_walk", Walk_Lamp, 1'b0);
    check("async_rst_pend", Walk_Pending, 1'b0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    Reset_n = 1'b1;
    meas_reset();
    n = 0;
    while (Main_Lights == 3'b001 && n < 400) begin run(1, 1'b0, 1'b0); n++; end
    check("rst_leave_mg", (n < 400), 1'b1);
    check("rst_mg_ticks", last_mg, 6);

    // Random traffic, including back-to-back Ticks and rare reprograms.
    for (int i = 0; i < 3000; i++)
      cycle(($urandom % 3) == 0, ($urandom % 2) == 1, ($urandom % 8) == 0, ($urandom % 64) == 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/traffic_light_fsm.md
TRAFFIC_LIGHT_FSM -- requirements
Module: traffic_light_fsm

Interface
REQ-001 Parameter T_BASE, default 6: base green duration, in Tick periods (1..15).
REQ-002 Parameter T_EXT, default 3: sensor-extension and walk duration, in Tick periods (1..15).
REQ-003 Parameter T_YEL, default 2: yellow duration, in Tick periods (1..15).
REQ-004 clk  input  1  single system clock, rising edge.
REQ-005 Reset_n  input  1  asynchronous, active-low hard reset.
REQ-006 Tick  input  1  one-clk-wide timing strobe (nominal 1 Hz), synchronous to clk.
REQ-007 Sensor_Sync  input  1  synchronized side-street vehicle sensor, level.
REQ-008 WR_Sync  input  1  synchronized walk request, level or pulse.
REQ-009 Prog_Sync  input  1  synchronized reprogram request; soft restart.
REQ-010 Main_Lights  output  3  main street lamps {R,Y,G}, one-hot.
REQ-011 Side_Lights  output  3  side street lamps {R,Y,G}, one-hot.
REQ-012 Walk_Lamp  output  1  pedestrian walk indicator.
REQ-013 Walk_Pending  output  1  a walk request is latched and not yet served.

Function
REQ-014 Moore FSM states: MG, MGX, MY, WALK, SG, SGX, SY.
REQ-015 Lamps per state: MG/MGX main G, side R; MY main Y, side R; WALK both R and Walk_Lamp=1; SG/SGX main R, side G; SY main R, side Y.
REQ-016 All outputs registered; they change on the same clk edge as the state.
REQ-017 4-bit down-counter loads (duration-1) on state entry; it decrements only when Tick=1.
REQ-018 A state exits on the clk edge where counter==0 and Tick=1, so each state lasts exactly its duration in Ticks.
REQ-019 Durations: MG=T_BASE, MGX=T_EXT, MY=T_YEL, WALK=T_EXT, SG=T_BASE, SGX=T_EXT, SY=T_YEL.
REQ-020 A parameter value of 0 is treated as 1; widths are clamped to 4 bits.
REQ-021 MG exit: if Sensor_Sync=1 on the exit edge, go to MGX; otherwise go to MY. MGX always goes to MY.
REQ-022 MY exit: if Walk_Pending=1, go to WALK; otherwise go to SG. WALK always goes to SG.
REQ-023 SG exit: if Sensor_Sync=1, go to SGX; otherwise go to SY. SGX always goes to SY. SY always goes to MG.
REQ-024 Walk_Pending sets on any clk where WR_Sync=1, except while in WALK or on the edge entering WALK (request ignored there).
REQ-025 Walk_Pending clears on the edge entering WALK.
REQ-026 Prog_Sync=1 at any edge forces the next state to MG, reloads the counter with T_BASE-1 and clears Walk_Pending.
REQ-027 Prog_Sync has priority over Tick expiry and WR_Sync in the same cycle.
REQ-028 Tick asserted on consecutive clks counts each clk; the counter never wraps below 0.
REQ-029 Unreachable state encodings recover to MG on the next edge.

Reset
REQ-030 Reset_n=0 asynchronously forces: state MG, counter T_BASE-1, Main_Lights=001, Side_Lights=100, Walk_Lamp=0, Walk_Pending=0.
REQ-031 After Reset_n deasserts, operation starts at the first clk edge, including reset asserted mid-state.

Configuration
REQ-032 Macro TLC_WALK_EN defined: WALK state and Walk_Pending logic are present as specified above.
REQ-033 Macro TLC_WALK_EN undefined: WALK is removed, MY always goes to SG, Walk_Lamp=0 and Walk_Pending=0 constantly, and WR_Sync is ignored; ports remain.

Verification
REQ-034 Defaults, Tick every 10 clk, all inputs 0 after reset: MG 6 Ticks, MY 2, SG 6, SY 2, back to MG; period 16 Ticks.
REQ-035 Sensor_Sync held 1: main green lasts 9 Ticks (MG+MGX), side green lasts 9 Ticks, period 22 Ticks.
REQ-036 One-clk WR_Sync pulse during MG: Walk_Pending=1 next edge; after MY, WALK for 3 Ticks with both R and Walk_Lamp=1; Walk_Pending=0 from WALK entry.
REQ-037 Prog_Sync one clk during SG with a pending walk: next edge MG, Main_Lights=001, Walk_Pending=0, MG lasts full 6 Ticks.
REQ-038 Reset_n low mid-SY between clk edges: outputs reach their reset values without a clk edge; MG timing restarts after release.
REQ-039 TLC_WALK_EN undefined, WR_Sync pulsed every cycle: Walk_Lamp and Walk_Pending stay 0, period 16 Ticks.
